// File: rtl/div_pkg.sv
// Shared definitions for the parametrised sequential divider.
// Holds the controller state encoding, the counter-width helper and the
// saturation constant helpers. Helpers return 64-bit values; callers slice
// them down to the width they need (supports WIDTH+FRAC up to 63).
package div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  // Number of bits needed to count 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Largest unsigned value in w bits.
  function automatic logic [63:0] sat_umax(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Largest positive two's-complement value in w bits.
  function automatic logic [63:0] sat_smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Magnitude of the most negative w-bit value; its low w bits are also the
  // bit pattern of that value.
  function automatic logic [63:0] sat_smin(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/seq_divider_param_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   rem_i   partial remainder going in (WIDTH+1 bits)
//   bit_i   next dividend bit, MSB first
//   dmag_i  divisor magnitude
//   rem_o   partial remainder coming out
//   qbit_o  quotient bit produced by this iteration
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dmag_i,
  output logic [WIDTH:0]   rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_rem_msb;

  // The remainder is always below the divisor, so its MSB is zero and the
  // shifted value still fits in WIDTH+1 bits.
  assign unused_rem_msb = rem_i[WIDTH];
  assign shifted        = {rem_i[WIDTH-1:0], bit_i};
  assign diff           = {1'b0, shifted} - {2'b00, dmag_i};

  // No borrow means the trial subtraction fits: keep it, quotient bit 1.
  assign qbit_o = ~diff[WIDTH+1];
  assign rem_o  = qbit_o ? diff[WIDTH:0] : shifted;

endmodule

// File: rtl/seq_divider_param.sv
// Multi-cycle restoring divider with configurable width, fixed-point
// fractional quotient bits, run-time signed/unsigned mode and remainder.
// Ports:
//   clk, sclr            clock, synchronous active-high reset
//   start                request, sampled only while idle
//   signed_mode          1 = two's-complement operands/results
//   in_a, in_b           dividend, divisor (sampled with start)
//   busy                 operation in progress
//   valid                one-cycle pulse, results and flags valid
//   qout, rout           quotient Q(WIDTH-FRAC).FRAC, remainder
//   ovf, dvz             quotient saturated, divide by zero
module seq_divider_param
  import div_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int FRAC  = 0
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] qout,
  output logic [WIDTH-1:0] rout,
  output logic             ovf,
  output logic             dvz
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [63:0] UMAX64 = sat_umax(WIDTH);
  localparam logic [63:0] SMAX64 = sat_smax(WIDTH);
  localparam logic [63:0] SMIN64 = sat_smin(WIDTH);

  // Overflow limits widened to the N-bit quotient magnitude (plus a guard bit).
  localparam logic [N:0] UMAX_N = UMAX64[N:0];
  localparam logic [N:0] SMAX_N = SMAX64[N:0];
  localparam logic [N:0] SMIN_N = SMIN64[N:0];

  // Saturated output patterns.
  localparam logic [WIDTH-1:0] UMAX_W = UMAX64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMAX_W = SMAX64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMIN_W = SMIN64[WIDTH-1:0];

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, dmag_q;
  logic             mode_q, qneg_q, rneg_q;
  logic [N-1:0]     sr_q;
  logic [WIDTH:0]   rem_q;

  logic             busy_q, valid_q, ovf_q, dvz_q;
  logic [WIDTH-1:0] qout_q, rout_q;

  logic             a_neg_d, b_neg_d;
  logic [WIDTH-1:0] a_mag_d, b_mag_d;
  logic [WIDTH:0]   step_rem_d;
  logic             step_qbit_d;
  logic [N:0]       qext_d;
  logic [WIDTH-1:0] q_low_d;
  logic             q_ovf_d;
  logic [WIDTH-1:0] q_fix_d, r_fix_d;

  // LOAD: operand magnitudes. In unsigned mode the operands are used as-is.
  assign a_neg_d = mode_q & a_q[WIDTH-1];
  assign b_neg_d = mode_q & b_q[WIDTH-1];
  assign a_mag_d = a_neg_d ? -a_q : a_q;
  assign b_mag_d = b_neg_d ? -b_q : b_q;

  // ITER: the shift register holds dividend bits at the top and collects
  // quotient bits at the bottom; after N steps it holds the full quotient.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .bit_i  (sr_q[N-1]),
    .dmag_i (dmag_q),
    .rem_o  (step_rem_d),
    .qbit_o (step_qbit_d)
  );

  // FIX: range check on the unsigned magnitude, then sign application.
  assign qext_d  = {1'b0, sr_q};
  assign q_low_d = sr_q[WIDTH-1:0];

  always_comb begin
    q_ovf_d = 1'b0;
    if (!mode_q)     q_ovf_d = (qext_d > UMAX_N);
    else if (qneg_q) q_ovf_d = (qext_d > SMIN_N);
    else             q_ovf_d = (qext_d > SMAX_N);
  end

  always_comb begin
    q_fix_d = qneg_q ? -q_low_d : q_low_d;
    if (q_ovf_d) begin
      if (!mode_q)     q_fix_d = UMAX_W;
      else if (qneg_q) q_fix_d = SMIN_W;
      else             q_fix_d = SMAX_W;
    end
  end

  assign r_fix_d = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  // Controller and datapath registers. Operand/datapath registers are only
  // meaningful while busy, so reset touches control and visible outputs only.
  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      qout_q  <= '0;
      rout_q  <= '0;
      ovf_q   <= 1'b0;
      dvz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= in_a;
            b_q     <= in_b;
            mode_q  <= signed_mode;
            busy_q  <= 1'b1;
            qout_q  <= '0;
            rout_q  <= '0;
            ovf_q   <= 1'b0;
            dvz_q   <= 1'b0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          qneg_q <= a_neg_d ^ b_neg_d;
          rneg_q <= a_neg_d;
          dmag_q <= b_mag_d;
          if (b_q == '0) begin
            dvz_q   <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            sr_q    <= N'(a_mag_d) << FRAC;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= ITER;
          end
        end
        ITER: begin
          sr_q  <= {sr_q[N-2:0], step_qbit_d};
          rem_q <= step_rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end
        end
        FIX: begin
          qout_q  <= q_fix_d;
          rout_q  <= r_fix_d;
          ovf_q   <= q_ovf_d;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign qout  = qout_q;
  assign rout  = rout_q;
  assign ovf   = ovf_q;
  assign dvz   = dvz_q;

endmodule

// File: tb/tb_seq_divider_param.sv
// Bench for seq_divider_param: two instances (FRAC=0 and FRAC=5, WIDTH=10)
// share one stimulus stream; a reference model computes each result with
// plain integer division and a single compare process checks every cycle.
module tb_seq_divider_param;

  localparam int W   = 10;
  localparam int FR1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         sclr, start, signed_mode;
  logic [W-1:0] in_a, in_b;
  logic         busy0, valid0, ovf0, dvz0;
  logic         busy1, valid1, ovf1, dvz1;
  logic [W-1:0] qout0, rout0, qout1, rout1;

  seq_divider_param #(.WIDTH(W), .FRAC(0)) dut0 (
    .clk(clk), .sclr(sclr), .start(start), .signed_mode(signed_mode),
    .in_a(in_a), .in_b(in_b), .busy(busy0), .valid(valid0),
    .qout(qout0), .rout(rout0), .ovf(ovf0), .dvz(dvz0)
  );

  seq_divider_param #(.WIDTH(W), .FRAC(FR1)) dut1 (
    .clk(clk), .sclr(sclr), .start(start), .signed_mode(signed_mode),
    .in_a(in_a), .in_b(in_b), .busy(busy1), .valid(valid1),
    .qout(qout1), .rout(rout1), .ovf(ovf1), .dvz(dvz1)
  );

  typedef struct {
    int           st;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
  } req_t;

  typedef struct {
    int           dut;
    int           st;
    int           due;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic [21:0]  res;   // {q, r, ovf, dvz}
  } rec_t;

  // Written by the stimulus only.
  req_t req_arr [128];
  int   req_n     = 0;
  int   flush_n   = 0;
  int   hold_last = -1;
  bit   checking  = 1'b0;

  // Written by the compare process only.
  rec_t        pend[$];
  logic [21:0] last_res [2];
  int          req_rd    = 0;
  int          flush_rd  = 0;
  int          total     = 0;
  int          bad       = 0;
  bit          pins_done = 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: truncating division of the scaled dividend, then saturation.
  function automatic logic [21:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic m, input int frac);
    longint sa, sb, num, q, r, qmax, qmin;
    logic   ov;
    logic [W-1:0] qo, ro;
    if (b == '0) return {20'd0, 1'b0, 1'b1};
    sa = (m && a[W-1]) ? longint'(a) - (longint'(1) << W) : longint'(a);
    sb = (m && b[W-1]) ? longint'(b) - (longint'(1) << W) : longint'(b);
    num  = sa * (longint'(1) << frac);
    q    = num / sb;
    r    = num % sb;
    qmax = m ? (longint'(1) << (W - 1)) - 1 : (longint'(1) << W) - 1;
    qmin = m ? -(longint'(1) << (W - 1)) : 0;
    ov   = (q > qmax) || (q < qmin);
    if (q > qmax) q = qmax;
    else if (q < qmin) q = qmin;
    qo = q[W-1:0];
    ro = r[W-1:0];
    return {qo, ro, ov, 1'b0};
  endfunction

  // Cycles from the accepting edge to the valid cycle.
  function automatic int lat(input int d, input logic [21:0] res);
    if (res[0]) return 1;
    return W + ((d == 0) ? 0 : FR1) + 2;
  endfunction

  task automatic add_rec(input int d, input int st, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic m);
    rec_t rc;
    rc.dut = d; rc.st = st; rc.a = a; rc.b = b; rc.m = m;
    rc.res = model(a, b, m, (d == 0) ? 0 : FR1);
    rc.due = st + lat(d, rc.res);
    pend.push_back(rc);
  endtask

  task automatic chk_pin(input string nm, input logic [21:0] got, input logic [21:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL pin_%s got=%h required=%h", nm, got, exp);
    end
  endtask

  // Single compare process.
  always @(negedge clk) begin : cmp
    logic [23:0] exp_v, got_v;
    int idx;
    req_t rq;
    rec_t rc;
    if (checking) begin
      if (!pins_done) begin
        last_res[0] = '0;
        last_res[1] = '0;
        chk_pin("u100_7",   model(10'd100, 10'd7, 1'b0, 0),   {10'd14, 10'd2, 2'b00});
        chk_pin("s-100_7",  model(10'h39C, 10'd7, 1'b1, 0),   {10'h3F2, 10'h3FE, 2'b00});
        chk_pin("s-512_-1", model(10'h200, 10'h3FF, 1'b1, 0), {10'd511, 10'd0, 2'b10});
        chk_pin("f5_3_2",   model(10'd3, 10'd2, 1'b0, 5),     {10'd48, 10'd0, 2'b00});
        chk_pin("f5_1000_3",model(10'd1000, 10'd3, 1'b0, 5),  {10'd1023, 10'd2, 2'b10});
        chk_pin("dvz55",    model(10'd55, 10'd0, 1'b1, 0),    {20'd0, 2'b01});
        chk_pin("u20_4",    model(10'd20, 10'd4, 1'b0, 0),    {10'd5, 10'd0, 2'b00});
        pins_done = 1'b1;
      end
      if (flush_rd != flush_n) begin
        pend.delete();
        last_res[0] = '0;
        last_res[1] = '0;
        flush_rd = flush_n;
      end
      while (req_rd < req_n) begin
        rq = req_arr[req_rd % 128];
        add_rec(0, rq.st, rq.a, rq.b, rq.m);
        add_rec(1, rq.st, rq.a, rq.b, rq.m);
        req_rd++;
      end
      for (int d = 0; d < 2; d++) begin
        idx = -1;
        for (int i = 0; i < pend.size(); i++)
          if (idx < 0 && pend[i].dut == d) idx = i;
        exp_v = {2'b00, last_res[d]};
        if (idx >= 0 && cyc >= pend[idx].st) begin
          if (cyc == pend[idx].due) begin
            rc = pend[idx];
            exp_v = {2'b01, rc.res};
            last_res[d] = rc.res;
            pend.delete(idx);
            if (hold_last >= 0 && rc.due + 2 <= hold_last)
              add_rec(d, rc.due + 2, rc.a, rc.b, rc.m);
          end else begin
            exp_v = {2'b10, 22'd0};
          end
        end
        got_v = (d == 0) ? {busy0, valid0, qout0, rout0, ovf0, dvz0}
                         : {busy1, valid1, qout1, rout1, ovf1, dvz1};
        total++;
        if (got_v !== exp_v) begin
          bad++;
          $display("FAIL dut%0d cyc=%0d busy/valid/q/r/ovf/dvz got=%b/%b/%h/%h/%b/%b required=%b/%b/%h/%h/%b/%b",
                   d, cyc, got_v[23], got_v[22], got_v[21:12], got_v[11:2], got_v[1], got_v[0],
                   exp_v[23], exp_v[22], exp_v[21:12], exp_v[11:2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  task automatic post(input int t, input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    req_arr[req_n % 128].st = t;
    req_arr[req_n % 128].a  = a;
    req_arr[req_n % 128].b  = b;
    req_arr[req_n % 128].m  = m;
    req_n++;
  endtask

  // Called 1 time unit after a rising edge; returns the accepting edge index.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        output int t);
    in_a = a; in_b = b; signed_mode = m; start = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    start = 1'b0;
    post(t, a, b, m);
    in_a = W'($urandom); in_b = W'($urandom); signed_mode = 1'($urandom);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((req_rd < req_n || pend.size() > 0) && n < 200) begin
      step();
      n++;
    end
    if (req_rd < req_n || pend.size() > 0) begin
      $display("FAIL idle_timeout pending=%0d required=0", pend.size());
      $fatal(1, "timeout");
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 10'd1;
      1: return 10'h200;
      2: return 10'h3FF;
      3: return 10'h1FF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int t;
    logic [W-1:0] ra, rb;
    logic rm;
    sclr = 1'b1; start = 1'b0; signed_mode = 1'b0; in_a = '0; in_b = '0;
    step();
    checking = 1'b1;
    step(); step();
    sclr = 1'b0;
    step();

    // Directed operations from the plan.
    launch(10'd100, 10'd7, 1'b0, t);    wait_idle();
    launch(10'h39C, 10'd7, 1'b1, t);    wait_idle();
    launch(10'h200, 10'h3FF, 1'b1, t);  wait_idle();
    launch(10'd3, 10'd2, 1'b0, t);      wait_idle();
    launch(10'd1000, 10'd3, 1'b0, t);   wait_idle();
    launch(10'd55, 10'd0, 1'b0, t);     wait_idle();
    launch(10'd20, 10'd4, 1'b0, t);     wait_idle();
    launch(10'd55, 10'd0, 1'b1, t);     wait_idle();
    launch(10'h3F0, 10'h002, 1'b1, t);  wait_idle();

    // Starts mid-ITER and in the DONE cycle of the FRAC=0 instance are ignored.
    launch(10'd700, 10'd9, 1'b0, t);
    wait_until(t + 4);
    in_a = 10'd1; in_b = 10'd1; start = 1'b1;
    step();
    start = 1'b0;
    wait_until(t + 12);
    in_a = 10'd5; in_b = 10'd3; start = 1'b1;
    step();
    start = 1'b0;
    wait_idle();

    // Reset during ITER cycle 4 aborts silently.
    launch(10'd1000, 10'd7, 1'b1, t);
    wait_until(t + 4);
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    flush_n++;
    step(); step(); step();
    launch(10'd200, 10'd9, 1'b0, t);    wait_idle();

    // start held high: back-to-back operations.
    hold_last = cyc + 41;
    in_a = 10'd77; in_b = 10'd5; signed_mode = 1'b0; start = 1'b1;
    step();
    post(cyc, 10'd77, 10'd5, 1'b0);
    wait_until(hold_last);
    start = 1'b0;
    wait_idle();
    hold_last = -1;

    // Randomised operations, some with an ignored start while busy.
    for (int i = 0; i < 40; i++) begin
      ra = pick();
      rb = pick();
      if ($urandom_range(0, 7) == 0) rb = '0;
      rm = 1'($urandom_range(0, 1));
      launch(ra, rb, rm, t);
      if (rb != '0 && $urandom_range(0, 2) == 0) begin
        step(); step(); step();
        in_a = pick(); in_b = pick(); start = 1'b1;
        step();
        start = 1'b0;
      end
      wait_idle();
    end

    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider_param.md
Name: seq_divider_param

Overview:
- Parametrised multi-cycle restoring divider; next generation of the fixed 10-bit unsigned divider.
- Adds configurable width, fixed-point fractional quotient bits, a run-time signed/unsigned mode, and a remainder output.
- Sits behind an ALU/accelerator front end: takes one start/operand pair, returns a quotient, remainder and status flags with a valid pulse.

Parameters:
- WIDTH, 10, bit width of dividend, divisor, quotient and remainder (>=4).
- FRAC, 0, number of fractional quotient bits (0..WIDTH-1); quotient is Q(WIDTH-FRAC).FRAC.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- sclr  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands/results; sampled with start.
- in_a  in  WIDTH  dividend; sampled with start.
- in_b  in  WIDTH  divisor; sampled with start.
- busy  out  1  operation in progress.
- valid  out  1  one-cycle pulse; results/flags valid.
- qout  out  WIDTH  quotient.
- rout  out  WIDTH  remainder.
- ovf  out  1  quotient not representable.
- dvz  out  1  divide by zero.

Behaviour:
- Reset values: busy=0, valid=0, qout=0, rout=0, ovf=0, dvz=0, state=IDLE. sclr wins over every other input, including mid-operation; the aborted result is never reported.
- States: IDLE -> LOAD -> ITER -> FIX -> DONE -> IDLE.
  - IDLE: start=1 latches in_a, in_b, signed_mode and moves to LOAD.
  - LOAD: busy=1. Forms magnitudes (abs in signed mode) and records the result signs.
    - Divisor==0: go to DONE with dvz=1, qout=0, rout=0, ovf=0.
    - Otherwise: load dividend magnitude left-shifted by FRAC into an N=WIDTH+FRAC bit shift register, clear the WIDTH+1 bit partial remainder, counter=0.
  - ITER: one quotient bit per cycle, MSB first. Shift remainder left, bring in the next dividend bit, subtract the divisor magnitude. If the result is non-negative keep it and set the quotient bit to 1; otherwise restore. Exactly N cycles; counter wraps at N-1.
  - FIX: apply signs. Quotient is negative iff operand signs differ; remainder takes the dividend's sign.
    - Overflow check on the N-bit magnitude. Unsigned: q >= 2^WIDTH. Signed: positive q > 2^(WIDTH-1)-1, negative q > 2^(WIDTH-1).
    - On overflow, qout saturates: unsigned all ones; signed max positive or min negative by result sign. ovf=1.
  - DONE: valid=1 for exactly this cycle, busy=0; then IDLE.
- Timing (start sampled at edge t):
  - Normal operation: busy=1 for cycles t+1..t+N+2; valid=1 at cycle t+N+3.
  - Divide by zero: busy=1 for t+1 only; valid at t+2.
- qout, rout, ovf and dvz hold their values from DONE until the next accepted start, then clear in LOAD.
- start while busy or in DONE is ignored (not queued). A start in the same cycle as valid is ignored.
- start held high continuously starts a new operation on the first IDLE cycle after DONE.
- Operand changes after sampling have no effect.

Decomposition:
- Shared package div_pkg:
  - state enum {IDLE, LOAD, ITER, FIX, DONE}.
  - Counter-width function clog2(WIDTH+FRAC).
  - Saturation constant helpers for max/min signed and unsigned.
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new remainder, quotient bit.
- Controller and datapath stay in this module.

Test Plan:
- WIDTH=10, FRAC=0, unsigned, in_a=100, in_b=7 -> qout=14, rout=2, ovf=0, dvz=0; valid exactly 13 cycles after start, busy high 12 cycles.
- Same parameters, signed, in_a=-100, in_b=7 -> qout=-14 (0x3F2), rout=-2 (0x3FE). Also in_a=-512, in_b=-1 -> ovf=1, qout=511.
- WIDTH=10, FRAC=5, unsigned:
  - in_a=3, in_b=2 -> qout=48 (1.5), rout=0, valid after 18 cycles.
  - in_a=1000, in_b=3 -> ovf=1, qout=1023.
- in_a=55, in_b=0, either mode -> dvz=1, qout=0, rout=0, valid 2 cycles after start. Next start 20/4 -> dvz cleared, qout=5.
- Assert start again mid-ITER with different operands -> ignored; the original result is returned unchanged at the expected cycle.
- Pulse sclr in ITER cycle 4 -> next cycle busy=0, valid=0, all outputs 0. No valid pulse follows; a new start completes normally.
